// File: rtl/vid_bbox_overlay_if.sv
// Video stream bundle: data enable, syncs and RGB888 pixel.
// The producer drives through the master modport, the consumer reads through slave.
interface vid_bbox_overlay_if;
    logic       de;
    logic       hs;
    logic       vs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;

    modport master (output de, hs, vs, r, g, b);
    modport slave  (input  de, hs, vs, r, g, b);
endinterface

// File: rtl/vid_bbox_overlay.sv
// Luminance-threshold bounding-box tracker with outline overlay.
// Foreground pixels of each frame are boxed; the box latched at the start of a
// frame is drawn over that frame's video, which is republished 2 cycles late.
module vid_bbox_overlay #(
    parameter int unsigned THRESH = 128,
    parameter logic [7:0]  BOX_R  = 8'hFF,
    parameter logic [7:0]  BOX_G  = 8'h00,
    parameter logic [7:0]  BOX_B  = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst,
    vid_bbox_overlay_if.slave         vin,
    vid_bbox_overlay_if.master        vout,
    output logic [10:0]               bbox_xmin,
    output logic [10:0]               bbox_xmax,
    output logic [10:0]               bbox_ymin,
    output logic [10:0]               bbox_ymax,
    output logic                      bbox_valid,
    output logic                      frame_done
);

    localparam logic [10:0] COORD_MAX = 11'd2047;
    localparam logic [8:0]  THRESH_L  = 9'(THRESH);

    // Coordinate counters stop at the top of their range instead of wrapping.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == COORD_MAX) ? v : v + 11'd1;
    endfunction

    // Y = (R + 2G + B) >> 2; the 10-bit sum cannot overflow (max 1020).
    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[9:2];
    endfunction

    logic        de_q;
    logic        vs_q;
    logic        vs_rise;
    logic        de_fall;
    logic        fg;
    logic [10:0] x;
    logic [10:0] y;

    logic        armed;
    logic [10:0] acc_xmin;
    logic [10:0] acc_xmax;
    logic [10:0] acc_ymin;
    logic [10:0] acc_ymax;
    logic        acc_hit;
    logic [10:0] nxt_xmin;
    logic [10:0] nxt_xmax;
    logic [10:0] nxt_ymin;
    logic [10:0] nxt_ymax;
    logic        nxt_hit;

    logic        de_p1;
    logic        hs_p1;
    logic        vs_p1;
    logic [7:0]  r_p1;
    logic [7:0]  g_p1;
    logic [7:0]  b_p1;
    logic [10:0] x_p1;
    logic [10:0] y_p1;
    logic        outline;

    // Edge strobes and foreground classification of the incoming pixel.
    always_comb begin
        vs_rise = vin.vs & ~vs_q;
        de_fall = ~vin.de & de_q;
        fg      = vin.de & ({1'b0, luma(vin.r, vin.g, vin.b)} >= THRESH_L);
    end

    // Registered copies of DE and VS for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            de_q <= vin.de;
            vs_q <= vin.vs;
        end
    end

    // Pixel position; x and y hold the coordinate of the pixel being presented.
    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else begin
            if (vin.de)
                x <= sat_inc(x);
            else if (de_fall)
                x <= '0;
            if (vs_rise)
                y <= '0;
            else if (de_fall)
                y <= sat_inc(y);
        end
    end

    // Next accumulator value: a frame start clears first, then a same-cycle
    // foreground pixel lands in the new frame's accumulators.
    always_comb begin
        nxt_xmin = vs_rise ? COORD_MAX : acc_xmin;
        nxt_xmax = vs_rise ? 11'd0     : acc_xmax;
        nxt_ymin = vs_rise ? COORD_MAX : acc_ymin;
        nxt_ymax = vs_rise ? 11'd0     : acc_ymax;
        nxt_hit  = vs_rise ? 1'b0      : acc_hit;
        if (fg) begin
            if (x < nxt_xmin) nxt_xmin = x;
            if (x > nxt_xmax) nxt_xmax = x;
            if (y < nxt_ymin) nxt_ymin = y;
            if (y > nxt_ymax) nxt_ymax = y;
            nxt_hit = 1'b1;
        end
    end

    // Per-frame accumulators and the arm flag that discards the first partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_xmin <= COORD_MAX;
            acc_xmax <= '0;
            acc_ymin <= COORD_MAX;
            acc_ymax <= '0;
            acc_hit  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            acc_xmin <= nxt_xmin;
            acc_xmax <= nxt_xmax;
            acc_ymin <= nxt_ymin;
            acc_ymax <= nxt_ymax;
            acc_hit  <= nxt_hit;
            armed    <= armed | vs_rise;
        end
    end

    // Latch the finished frame's box at frame start; an empty frame keeps the old box.
    always_ff @(posedge clk) begin
        if (rst) begin
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
            bbox_valid <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= vs_rise & armed;
            if (vs_rise && armed) begin
                bbox_valid <= acc_hit;
                if (acc_hit) begin
                    bbox_xmin <= acc_xmin;
                    bbox_xmax <= acc_xmax;
                    bbox_ymin <= acc_ymin;
                    bbox_ymax <= acc_ymax;
                end
            end
        end
    end

    // Stage 1: capture the pixel with its coordinate; only timing signals need reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_p1 <= 1'b0;
            hs_p1 <= 1'b0;
            vs_p1 <= 1'b0;
        end else begin
            de_p1 <= vin.de;
            hs_p1 <= vin.hs;
            vs_p1 <= vin.vs;
        end
        r_p1 <= vin.r;
        g_p1 <= vin.g;
        b_p1 <= vin.b;
        x_p1 <= x;
        y_p1 <= y;
    end

    // Outline test of the stage-1 pixel against the currently latched box.
    always_comb begin
        outline = bbox_valid & de_p1 &
                  ((((x_p1 == bbox_xmin) || (x_p1 == bbox_xmax)) &&
                    (y_p1 >= bbox_ymin) && (y_p1 <= bbox_ymax)) ||
                   (((y_p1 == bbox_ymin) || (y_p1 == bbox_ymax)) &&
                    (x_p1 >= bbox_xmin) && (x_p1 <= bbox_xmax)));
    end

    // Stage 2: output register; blanking forces colour to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            vout.de <= 1'b0;
            vout.hs <= 1'b0;
            vout.vs <= 1'b0;
            vout.r  <= '0;
            vout.g  <= '0;
            vout.b  <= '0;
        end else begin
            vout.de <= de_p1;
            vout.hs <= hs_p1;
            vout.vs <= vs_p1;
            vout.r  <= !de_p1 ? 8'd0 : (outline ? BOX_R : r_p1);
            vout.g  <= !de_p1 ? 8'd0 : (outline ? BOX_G : g_p1);
            vout.b  <= !de_p1 ? 8'd0 : (outline ? BOX_B : b_p1);
        end
    end

endmodule

// File: tb/tb_vid_bbox_overlay.sv
// Bench for vid_bbox_overlay: frames of a 64x64 format are streamed while a
// frame-level reference model predicts video, box outputs and frame_done.
module tb_vid_bbox_overlay;

    localparam int H_TOTAL = 82;   // sync 2, back porch 8, active 64, front porch 8
    localparam int V_TOTAL = 84;   // sync 4, back porch 8, active 64, front porch 8
    localparam int H_ACT0  = 10;
    localparam int V_ACT0  = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vid_bbox_overlay_if vin();
    vid_bbox_overlay_if vout();

    logic [10:0] bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax;
    logic        bbox_valid, frame_done;

    vid_bbox_overlay dut (
        .clk        (clk),
        .rst        (rst),
        .vin        (vin),
        .vout       (vout),
        .bbox_xmin  (bbox_xmin),
        .bbox_xmax  (bbox_xmax),
        .bbox_ymin  (bbox_ymin),
        .bbox_ymax  (bbox_ymax),
        .bbox_valid (bbox_valid),
        .frame_done (frame_done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Frame image, indexed [row][col]
    logic [7:0] img_r [64][64];
    logic [7:0] img_g [64][64];
    logic [7:0] img_b [64][64];

    // Reference model state
    bit          m_armed;
    bit          m_prev_vs;
    int          a_x0, a_x1, a_y0, a_y1;
    bit          a_hit;
    logic [10:0] bx0, bx1, by0, by1;
    bit          bvalid;
    bit          exp_fd;
    bit          have_prev = 0;
    int          fd_count = 0;
    logic [26:0] exp_q[$];

    function automatic bit on_box(input int col, input int row);
        return ((col == int'(bx0) || col == int'(bx1)) && row >= int'(by0) && row <= int'(by1)) ||
               ((row == int'(by0) || row == int'(by1)) && col >= int'(bx0) && col <= int'(bx1));
    endfunction

    task automatic clear_acc();
        a_x0 = 2047; a_x1 = 0; a_y0 = 2047; a_y1 = 0; a_hit = 0;
    endtask

    // One pixel clock: check what the DUT shows now, then present the next input.
    task automatic tick(input bit r_v, input bit de_v, input bit hs_v, input bit vs_v,
                        input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                        input int col, input int row);
        logic [26:0] e;
        bit          sof;
        int          lum;
        @(negedge clk);
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            expect_eq("video", {vout.de, vout.hs, vout.vs, vout.r, vout.g, vout.b}, e);
        end
        if (have_prev) begin
            expect_eq("frame_done", frame_done, exp_fd);
            expect_eq("bbox", {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
                      {bvalid, bx0, bx1, by0, by1});
            if (frame_done === 1'b1) fd_count++;
        end
        rst = r_v; vin.de = de_v; vin.hs = hs_v; vin.vs = vs_v;
        vin.r = rr; vin.g = gg; vin.b = bb;
        if (r_v) begin
            m_armed = 0; m_prev_vs = 0; clear_acc();
            bx0 = 0; bx1 = 0; by0 = 0; by1 = 0; bvalid = 0; exp_fd = 0;
            if (exp_q.size() > 0) exp_q[exp_q.size()-1] = '0;
            exp_q.push_back('0);
        end else begin
            sof = vs_v && !m_prev_vs;
            m_prev_vs = vs_v;
            exp_fd = sof && m_armed;
            if (sof) begin
                if (m_armed) begin
                    bvalid = a_hit;
                    if (a_hit) begin
                        bx0 = 11'(a_x0); bx1 = 11'(a_x1); by0 = 11'(a_y0); by1 = 11'(a_y1);
                    end
                end
                m_armed = 1;
                clear_acc();
            end
            lum = (int'(rr) + 2 * int'(gg) + int'(bb)) / 4;
            if (de_v && lum >= 128) begin
                if (col < a_x0) a_x0 = col;
                if (col > a_x1) a_x1 = col;
                if (row < a_y0) a_y0 = row;
                if (row > a_y1) a_y1 = row;
                a_hit = 1;
            end
            if (!de_v)
                e = {1'b0, hs_v, vs_v, 24'h0};
            else if (bvalid && on_box(col, row))
                e = {1'b1, hs_v, vs_v, 24'hFF0000};
            else
                e = {1'b1, hs_v, vs_v, rr, gg, bb};
            exp_q.push_back(e);
        end
        have_prev = 1;
    endtask

    // Stream nlines lines of the current image; optional 3-cycle reset at (rst_line, rst_col).
    task automatic send_frame(input int nlines, input int rst_line, input int rst_col);
        bit act;
        for (int ln = 0; ln < nlines; ln++) begin
            for (int c = 0; c < H_TOTAL; c++) begin
                act = (ln >= V_ACT0) && (ln < V_ACT0 + 64) && (c >= H_ACT0) && (c < H_ACT0 + 64);
                if (act)
                    tick(ln == rst_line && c >= rst_col && c < rst_col + 3, 1'b1, c < 2, ln < 4,
                         img_r[ln-V_ACT0][c-H_ACT0], img_g[ln-V_ACT0][c-H_ACT0],
                         img_b[ln-V_ACT0][c-H_ACT0], c - H_ACT0, ln - V_ACT0);
                else
                    tick(ln == rst_line && c >= rst_col && c < rst_col + 3, 1'b0, c < 2, ln < 4,
                         8'($urandom), 8'($urandom), 8'($urandom), -1, -1);
            end
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                img_r[r][c] = v; img_g[r][c] = v; img_b[r][c] = v;
            end
    endtask

    task automatic put(input int col, input int row, input logic [7:0] v);
        img_r[row][col] = v; img_g[row][col] = v; img_b[row][col] = v;
    endtask

    task automatic fill_random(input bit sparse);
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                if (sparse) begin
                    img_r[r][c] = 8'($urandom_range(63));
                    img_g[r][c] = 8'($urandom_range(63));
                    img_b[r][c] = 8'($urandom_range(63));
                end else begin
                    img_r[r][c] = 8'($urandom); img_g[r][c] = 8'($urandom); img_b[r][c] = 8'($urandom);
                end
            end
        if (sparse)
            for (int k = 0; k < 5; k++) put($urandom_range(63), $urandom_range(63), 8'hFF);
    endtask

    int fd0;

    initial begin
        vin.de = 0; vin.hs = 0; vin.vs = 0; vin.r = 0; vin.g = 0; vin.b = 0;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, -1, -1);
        expect_eq("reset_bbox", {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax}, 45'h0);

        // Frame 0: random image, 3-cycle reset mid-line
        fill_random(1'b0);
        fd0 = fd_count; send_frame(V_TOTAL, 30, 40);
        expect_eq("fd_frame0", fd_count - fd0, 0);

        // Frame 1: all black; its start only arms the block
        fill(8'h00);
        fd0 = fd_count; send_frame(V_TOTAL, -1, -1);
        expect_eq("fd_arm", fd_count - fd0, 0);

        // Frame 2: single white pixel at (10,20); start latches the black frame
        fill(8'h00); put(10, 20, 8'hFF);
        fd0 = fd_count; send_frame(V_TOTAL, -1, -1);
        expect_eq("fd_black", fd_count - fd0, 1);
        expect_eq("black_valid", bbox_valid, 1'b0);

        // Frame 3: rectangle (5,7)-(40,50)
        fill(8'h00);
        for (int r = 7; r <= 50; r++) for (int c = 5; c <= 40; c++) put(c, r, 8'hFF);
        fd0 = fd_count; send_frame(V_TOTAL, -1, -1);
        expect_eq("fd_dot", fd_count - fd0, 1);
        expect_eq("dot_box", {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
                  {1'b1, 11'd10, 11'd10, 11'd20, 11'd20});

        // Frame 4: threshold boundary, grey 127 at (3,3), grey 128 at (60,60)
        fill(8'h00); put(3, 3, 8'd127); put(60, 60, 8'd128);
        send_frame(V_TOTAL, -1, -1);
        expect_eq("rect_box", {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
                  {1'b1, 11'd5, 11'd40, 11'd7, 11'd50});

        // Frame 5: empty frame
        fill(8'h00);
        send_frame(V_TOTAL, -1, -1);
        expect_eq("thresh_box", {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
                  {1'b1, 11'd60, 11'd60, 11'd60, 11'd60});

        // Frame 6: random full-colour frame (no outline drawn over it)
        fill_random(1'b0);
        send_frame(V_TOTAL, -1, -1);
        expect_eq("empty_hold", {bbox_valid, bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax},
                  {1'b0, 11'd60, 11'd60, 11'd60, 11'd60});

        // Frame 7: dark frame with a few random bright pixels
        fill_random(1'b1);
        fd0 = fd_count; send_frame(V_TOTAL, -1, -1);
        expect_eq("fd_frame7", fd_count - fd0, 1);

        // Trailing sync lines latch frame 7 and flush the pipeline
        fd0 = fd_count; send_frame(5, -1, -1);
        expect_eq("fd_tail", fd_count - fd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
